// File: rtl/bus_cycle_ctrl.sv
// 8088-style minimum-mode bus master: arbitrates two requesters round-robin and
// sequences T1/T2/T3/Tw/T4 on a multiplexed ALE/RD/WR/CS/A/AD bus.
module bus_cycle_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            REQ,
    input  logic [1:0]            REQ_WE,
    input  logic [2*ADDR_W-1:0]   REQ_ADDR,
    input  logic [2*DATA_W-1:0]   REQ_WDATA,
    output logic [1:0]            GNT,
    output logic [1:0]            DONE,
    output logic                  ERR,
    output logic [DATA_W-1:0]     RDATA,
    output logic                  BUSY,
    output logic                  ALE,
    output logic                  RD,
    output logic                  WR,
    output logic                  CS,
    output logic [ADDR_W-DATA_W-1:0] A,
    inout  wire  [DATA_W-1:0]     AD,
    input  logic                  READY
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_T1   = 6'b000010,
        S_T2   = 6'b000100,
        S_T3   = 6'b001000,
        S_TW   = 6'b010000,
        S_T4   = 6'b100000
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_timeout;

    logic                w_win;
    logic                w_grant;
    logic                w_wait_last;
    logic                w_strobe;
    logic                w_ad_oe;
    logic [DATA_W-1:0]   w_ad_out;

    // Tie goes to the requester that was not granted last.
    assign w_win       = (REQ == 2'b11) ? ~r_last : REQ[1];
    assign w_grant     = (r_state == S_IDLE) && (|REQ) && !RESET;
    assign w_wait_last = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|REQ) w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = READY ? S_T4 : S_TW;
            S_TW:    if (READY || w_wait_last) w_next = S_T4;
            S_T4:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner <= w_win;
                r_last  <= w_win;
                r_we    <= w_win ? REQ_WE[1] : REQ_WE[0];
                r_addr  <= w_win ? REQ_ADDR[ADDR_W +: ADDR_W] : REQ_ADDR[0 +: ADDR_W];
                r_wdata <= w_win ? REQ_WDATA[DATA_W +: DATA_W] : REQ_WDATA[0 +: DATA_W];
            end
            if (r_state == S_T3) begin
                r_wait_cnt <= '0;
                r_timeout  <= 1'b0;
            end else if (r_state == S_TW) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                r_timeout  <= !READY && w_wait_last;
            end
            // Read data is taken on the edge leaving T3/TW, timeout included.
            if ((r_state == S_T3 || r_state == S_TW) && w_next == S_T4 && !r_we) begin
                r_rdata <= AD;
            end
        end
    end

    assign w_strobe = (r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW);
    assign w_ad_oe  = (r_state == S_T1) || (r_we && (w_strobe || r_state == S_T4));
    assign w_ad_out = (r_state == S_T1) ? r_addr[DATA_W-1:0] : r_wdata;

    assign GNT   = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign DONE  = (r_state == S_T4) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign ERR   = (r_state == S_T4) && r_timeout;
    assign RDATA = r_rdata;
    assign BUSY  = (r_state != S_IDLE);
    assign CS    = BUSY;
    assign ALE   = (r_state == S_T1);
    assign RD    = !(w_strobe && !r_we);
    assign WR    = !(w_strobe && r_we);
    assign A     = BUSY ? r_addr[ADDR_W-1:DATA_W] : '0;
    assign AD    = w_ad_oe ? w_ad_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: table of single transactions plus hand-written
// reset, round-robin and mid-cycle reset sequences; DONE checked by a scoreboard.
module tb_bus_cycle_ctrl;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [19:0] addr0;
        logic [19:0] addr1;
        logic [7:0]  wd0;
        logic [7:0]  wd1;
        logic [7:0]  pdata;
        int          ready_low;
        logic [1:0]  exp_gnt;
        logic [11:0] exp_a;
        logic [7:0]  exp_adlo;
        logic        exp_write;
        logic [7:0]  exp_wdata;
        int          exp_ofs;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0] done;
        logic       err;
        logic [7:0] rdata;
        int         cyc;
    } sb_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  REQ;
    logic [1:0]  REQ_WE;
    logic [39:0] REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic        ERR;
    logic [7:0]  RDATA;
    logic        BUSY;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        CS;
    logic [11:0] A;
    wire  [7:0]  AD;
    logic        READY;

    logic [7:0]  periph_data;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    sb_t         sb_q[$];
    sb_t         mon_e;
    vec_t        vecs[8];

    bus_cycle_ctrl dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .BUSY(BUSY), .ALE(ALE), .RD(RD), .WR(WR), .CS(CS), .A(A), .AD(AD), .READY(READY)
    );

    // Peripheral returns data while RD is low; an idle bus is driven to 0xEE so a
    // master that fails to release AD shows up as a corrupted value.
    assign AD = !RD ? periph_data : (!CS ? 8'hEE : 8'hzz);

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RESET && DONE != 2'b00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {30'd0, DONE}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_owner", {30'd0, DONE}, {30'd0, mon_e.done});
                check("done_cycle", cyc, mon_e.cyc);
                check("done_err", {31'd0, ERR}, {31'd0, mon_e.err});
                check("done_rdata", {24'd0, RDATA}, {24'd0, mon_e.rdata});
            end
        end
    end

    task automatic run_txn(input vec_t v, input int idx);
        string p;
        sb_t   e;
        logic [1:0] strobes;
        p = $sformatf("v%0d", idx);
        strobes = v.exp_write ? 2'b10 : 2'b01;   // {RD, WR}
        REQ = v.req;
        REQ_WE = v.we;
        REQ_ADDR = {v.addr1, v.addr0};
        REQ_WDATA = {v.wd1, v.wd0};
        periph_data = v.pdata;
        READY = 1'b1;
        #1;
        check({p, "_gnt"}, {30'd0, GNT}, {30'd0, v.exp_gnt});
        e.done = v.exp_gnt;
        e.err = v.exp_err;
        e.rdata = v.exp_rdata;
        e.cyc = cyc + v.exp_ofs;
        sb_q.push_back(e);
        step();
        REQ = 2'b00;
        #1;
        check({p, "_t1_ale_cs"}, {30'd0, ALE, CS}, 32'h3);
        check({p, "_t1_a"}, {20'd0, A}, {20'd0, v.exp_a});
        check({p, "_t1_ad"}, {24'd0, AD}, {24'd0, v.exp_adlo});
        step();
        #1;
        check({p, "_t2_ale"}, {31'd0, ALE}, 32'd0);
        check({p, "_t2_strobe"}, {30'd0, RD, WR}, {30'd0, strobes});
        if (v.exp_write) check({p, "_t2_ad"}, {24'd0, AD}, {24'd0, v.exp_wdata});
        for (int c = 3; c < v.exp_ofs; c++) begin
            step();
            READY = (c - 3 < v.ready_low) ? 1'b0 : 1'b1;
            #1;
            check({p, "_wait_strobe"}, {30'd0, RD, WR}, {30'd0, strobes});
            check({p, "_wait_done_err"}, {29'd0, DONE, ERR}, 32'd0);
            if (v.exp_write) check({p, "_wait_ad"}, {24'd0, AD}, {24'd0, v.exp_wdata});
        end
        step();
        READY = 1'b1;
        #1;
        check({p, "_t4_bus"}, {28'd0, RD, WR, CS, BUSY}, 32'hF);
        check({p, "_t4_a"}, {20'd0, A}, {20'd0, v.exp_a});
        if (v.exp_write) check({p, "_t4_ad"}, {24'd0, AD}, {24'd0, v.exp_wdata});
        step();
        #1;
        check({p, "_idle_busy_cs"}, {30'd0, BUSY, CS}, 32'd0);
        check({p, "_idle_ad"}, {24'd0, AD}, 32'hEE);
    endtask

    initial begin
        int prev_ale;
        logic [1:0] rr_exp[4];

        //           req    we     addr0     addr1     wd0    wd1    pdata  rl  gnt    A       adlo   wr    wdata  ofs err  rdata
        vecs[0] = '{2'b01, 2'b00, 20'h12345, 20'h00000, 8'h00, 8'h00, 8'hA5, 0,  2'b01, 12'h123, 8'h45, 1'b0, 8'h00, 4,  1'b0, 8'hA5};
        vecs[1] = '{2'b10, 2'b10, 20'h00000, 20'h00F10, 8'h00, 8'h3C, 8'h00, 0,  2'b10, 12'h00F, 8'h10, 1'b1, 8'h3C, 4,  1'b0, 8'hA5};
        vecs[2] = '{2'b01, 2'b00, 20'hABCDE, 20'h00000, 8'h00, 8'h00, 8'h69, 3,  2'b01, 12'hABC, 8'hDE, 1'b0, 8'h00, 7,  1'b0, 8'h69};
        vecs[3] = '{2'b10, 2'b00, 20'h00000, 20'h80001, 8'h00, 8'h00, 8'hC3, 99, 2'b10, 12'h800, 8'h01, 1'b0, 8'h00, 19, 1'b1, 8'hC3};
        vecs[4] = '{2'b11, 2'b01, 20'h0FFFF, 20'h77777, 8'h81, 8'h18, 8'h00, 0,  2'b01, 12'h0FF, 8'hFF, 1'b1, 8'h81, 4,  1'b0, 8'hC3};
        vecs[5] = '{2'b01, 2'b01, 20'h55AA0, 20'h00000, 8'h7E, 8'h00, 8'h00, 2,  2'b01, 12'h55A, 8'hA0, 1'b1, 8'h7E, 6,  1'b0, 8'hC3};
        vecs[6] = '{2'b11, 2'b00, 20'h11111, 20'h2468A, 8'h00, 8'h00, 8'h5C, 1,  2'b10, 12'h246, 8'h8A, 1'b0, 8'h00, 5,  1'b0, 8'h5C};
        vecs[7] = '{2'b10, 2'b00, 20'h00000, 20'h13579, 8'h00, 8'h00, 8'h42, 0,  2'b10, 12'h135, 8'h79, 1'b0, 8'h00, 4,  1'b0, 8'h42};
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        RESET = 1'b1;
        REQ = 2'b00;
        REQ_WE = 2'b00;
        REQ_ADDR = '0;
        REQ_WDATA = '0;
        READY = 1'b1;
        periph_data = 8'h00;
        repeat (3) step();
        RESET = 1'b0;
        #1;
        check("rst_strobes", {28'd0, ALE, RD, WR, CS}, 32'h6);
        check("rst_a", {20'd0, A}, 32'd0);
        check("rst_ad", {24'd0, AD}, 32'hEE);
        check("rst_gnt_done_err", {27'd0, GNT, DONE, ERR}, 32'd0);
        check("rst_rdata_busy", {23'd0, RDATA, BUSY}, 32'd0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Write from requester 0 interrupted by reset while in TW.
        REQ = 2'b01;
        REQ_WE = 2'b01;
        REQ_ADDR = {20'h00000, 20'h24680};
        REQ_WDATA = {8'h00, 8'h99};
        #1;
        check("mr_gnt", {30'd0, GNT}, 32'h1);
        step();
        REQ = 2'b00;
        step();
        step();
        READY = 1'b0;
        step();
        READY = 1'b0;
        #1;
        check("mr_tw_wr", {30'd0, RD, WR}, 32'h2);
        check("mr_tw_ad", {24'd0, AD}, 32'h99);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        READY = 1'b1;
        #1;
        check("mr_strobes", {28'd0, ALE, RD, WR, CS}, 32'h6);
        check("mr_a_busy", {19'd0, A, BUSY}, 32'd0);
        check("mr_ad", {24'd0, AD}, 32'hEE);
        check("mr_done_err", {29'd0, DONE, ERR}, 32'd0);
        check("mr_rdata", {24'd0, RDATA}, 32'd0);
        step();
        #1;
        check("mr_idle", {28'd0, DONE, BUSY, ERR}, 32'd0);

        // Both requesters held high: grants alternate starting at 0 after reset.
        REQ_WE = 2'b00;
        REQ_ADDR = {20'h2AAAA, 20'h15555};
        REQ = 2'b11;
        prev_ale = 0;
        for (int t = 0; t < 4; t++) begin
            sb_t e;
            periph_data = 8'(16 + t);
            #1;
            check($sformatf("rr%0d_gnt", t), {30'd0, GNT}, {30'd0, rr_exp[t]});
            e.done = rr_exp[t];
            e.err = 1'b0;
            e.rdata = 8'(16 + t);
            e.cyc = cyc + 4;
            sb_q.push_back(e);
            step();
            if (t == 3) REQ = 2'b00;
            #1;
            check($sformatf("rr%0d_ale", t), {31'd0, ALE}, 32'd1);
            if (t > 0) check($sformatf("rr%0d_ale_gap", t), cyc - prev_ale, 32'd5);
            prev_ale = cyc;
            repeat (4) step();
        end

        run_txn(vecs[7], 7);

        repeat (3) step();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
